// File: rtl/bf_out_uart.sv
// OUTP byte sink: FIFO-buffered UART transmitter (8N1, LSB first, idle high).
// Define BF_UART_PARITY_EN for an even-parity bit after data (8E1 framing).
module bf_out_uart #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               out_valid,
    input  logic [7:0]         out_data,
    output logic               out_ready,
    output logic               tx,
    output logic               busy,
    output logic               overflow,
    output logic [FIFO_AW:0]   level
);

    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state_q, state_d;

    logic [BW-1:0]      baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_d;
    logic               last;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]         head;
    logic               full, empty, push, pop;

`ifdef BF_UART_PARITY_EN
    logic par_q;
`endif

    assign full      = (level == FULL_LVL);
    assign empty     = (level == '0);
    assign out_ready = !full;
    assign push      = out_valid && !full;
    assign head      = mem[rd_ptr];
    assign busy      = (state_q != IDLE) || !empty;
    assign last      = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= out_data;
        end
    end

    // Full is judged on the registered level, so a same-cycle pop cannot rescue a push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (out_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx      <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx      <= tx_d;
        end
    end

`ifdef BF_UART_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (pop) begin
            par_q <= ^head;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        baud_d  = last ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = START;
                end
            end
            START: begin
                if (last) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (last) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef BF_UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef BF_UART_PARITY_EN
            PARITY: begin
                if (last) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Chain straight into the next start bit when more bytes wait.
                if (last) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef BF_UART_PARITY_EN
            PARITY:  tx_d = par_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_bf_out_uart.sv
// Directed bench for bf_out_uart: line decoder plus byte scoreboard.
// Frame length follows BF_UART_PARITY_EN when it is defined.
module tb_bf_out_uart;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_AW    = 2;
`ifdef BF_UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = CLK_DIV * FRAME_BITS;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             out_valid = 1'b0;
    logic [7:0]       out_data = 8'h00;
    logic             out_ready;
    logic             tx;
    logic             busy;
    logic             overflow;
    logic [FIFO_AW:0] level;

    bf_out_uart #(
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH),
        .FIFO_AW   (FIFO_AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .tx       (tx),
        .busy     (busy),
        .overflow (overflow),
        .level    (level)
    );

    always #5 clk = ~clk;

    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] sb[$];
    int         starts[$];
    int         n_frames = 0;
    int         cyc = 0;
    int         mcnt = -1;
    int         bi;
    logic [7:0] rx = 8'h00;
    logic [7:0] exp_b;
    int         f0;
    int         s0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Line decoder: samples each bit one cycle into its window.
    always @(negedge clk) begin
        cyc++;
        if (rst_n !== 1'b1) begin
            mcnt = -1;
        end else if (mcnt < 0) begin
            if (tx === 1'b0) begin
                mcnt = 0;
                starts.push_back(cyc);
            end
        end else begin
            mcnt++;
        end
        if (mcnt >= 0 && (mcnt % CLK_DIV) == 1) begin
            bi = mcnt / CLK_DIV;
            if (bi == 0) begin
                chk("start_bit", {31'd0, tx}, 32'd0);
            end else if (bi <= 8) begin
                rx[bi-1] = tx;
`ifdef BF_UART_PARITY_EN
            end else if (bi == 9) begin
                chk("parity_bit", {31'd0, tx}, {31'd0, ^rx});
`endif
            end
            if (bi == FRAME_BITS - 1) begin
                chk("stop_bit", {31'd0, tx}, 32'd1);
                chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
                exp_b = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
                chk("rx_byte", {24'd0, rx}, {24'd0, exp_b});
                n_frames++;
                mcnt = -1;
            end
        end
    end

    task automatic push(input logic [7:0] d, input logic exp_acc);
        out_valid = 1'b1;
        out_data  = d;
        chk("push_ready", {31'd0, out_ready}, {31'd0, exp_acc});
        if (out_ready === 1'b1) sb.push_back(d);
        @(negedge clk);
        out_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim, input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_ready", {31'd0, out_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single byte
        f0 = n_frames;
        push(8'h41, 1'b1);
        chk("t2_tx_before_pop", {31'd0, tx}, 32'd1);
        chk("t2_level1", {29'd0, level}, 32'd1);
        @(negedge clk);
        chk("t2_tx_start", {31'd0, tx}, 32'd0);
        chk("t2_level0", {29'd0, level}, 32'd0);
        chk("t2_busy", {31'd0, busy}, 32'd1);
        repeat (FRAME_CYC - 1) @(negedge clk);
        chk("t2_busy_last", {31'd0, busy}, 32'd1);
        chk("t2_tx_stop", {31'd0, tx}, 32'd1);
        @(negedge clk);
        chk("t2_busy_end", {31'd0, busy}, 32'd0);
        chk("t2_frames", n_frames - f0, 32'd1);

        // back-to-back bytes, no idle gap
        f0 = n_frames;
        s0 = starts.size();
        push(8'h48, 1'b1);
        push(8'h69, 1'b1);
        chk("t3_tx_start", {31'd0, tx}, 32'd0);
        chk("t3_level1", {29'd0, level}, 32'd1);
        repeat (FRAME_CYC - 1) @(negedge clk);
        chk("t3_level_hold", {29'd0, level}, 32'd1);
        @(negedge clk);
        chk("t3_level0", {29'd0, level}, 32'd0);
        chk("t3_tx_start2", {31'd0, tx}, 32'd0);
        repeat (FRAME_CYC - 1) @(negedge clk);
        chk("t3_busy_last", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("t3_busy_end", {31'd0, busy}, 32'd0);
        chk("t3_frames", n_frames - f0, 32'd2);
        chk("t3_nstarts", starts.size() - s0, 32'd2);
        if (starts.size() >= s0 + 2)
            chk("t3_gap", starts[s0+1] - starts[s0], FRAME_CYC);

        // overflow
        f0 = n_frames;
        for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i), 1'b1);
        push(8'hA5, 1'b0);
        chk("t4_ovf", {31'd0, overflow}, 32'd1);
        chk("t4_level_full", {29'd0, level}, 32'd4);
        chk("t4_ready_low", {31'd0, out_ready}, 32'd0);
        wait_idle(6 * FRAME_CYC, "t4_idle");
        chk("t4_frames", n_frames - f0, 32'd5);
        chk("t4_sb_empty", sb.size(), 32'd0);
        chk("t4_ovf_sticky", {31'd0, overflow}, 32'd1);

        // reset mid-frame with bytes queued
        push(8'hFF, 1'b1);
        push(8'hA1, 1'b1);
        push(8'hB2, 1'b1);
        chk("t5_level2", {29'd0, level}, 32'd2);
        repeat (16) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        f0 = n_frames;
        @(negedge clk);
        chk("t5_tx", {31'd0, tx}, 32'd1);
        chk("t5_level", {29'd0, level}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_ovf_clr", {31'd0, overflow}, 32'd0);
        chk("t5_ready", {31'd0, out_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * FRAME_CYC) @(negedge clk);
        chk("t5_no_frames", n_frames - f0, 32'd0);
        chk("t5_tx_idle", {31'd0, tx}, 32'd1);
        chk("t5_busy_idle", {31'd0, busy}, 32'd0);

        // frame length (parity bits checked by the decoder when enabled)
        f0 = n_frames;
        s0 = starts.size();
        push(8'h07, 1'b1);
        push(8'h03, 1'b1);
        wait_idle(3 * FRAME_CYC + 8, "t6_idle");
        chk("t6_frames", n_frames - f0, 32'd2);
        chk("t6_nstarts", starts.size() - s0, 32'd2);
        if (starts.size() >= s0 + 2)
            chk("t6_frame_len", starts[s0+1] - starts[s0], FRAME_CYC);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
